// File: rtl/pfb_coeff_ctrl.sv
// pfb_coeff_ctrl: double-buffered window coefficient store for one real PFB lane.
//
// Two banks each hold TAPS x PFB_SIZE coefficients. Host writes always land in the
// shadow bank (~active_bank). A commit arms a swap that takes effect on the next
// frame-start sample, so a frame is never filtered with a mix of two coefficient sets.
// Every lane sample gets its TAPS coefficients two cycles later, alongside delayed
// copies of its valid and sync.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   cfg_addr      {tap, index} write address, tap in the upper bits
//   cfg_data      coefficient to write
//   cfg_valid     write request
//   cfg_ready     write/commit acceptance (low while a swap is pending or in reset)
//   cfg_err       one-cycle pulse after an accepted write whose tap >= TAPS
//   commit        request a bank swap at the next frame start
//   commit_done   one-cycle pulse on the cycle the swap takes effect
//   active_bank   bank currently feeding the datapath
//   din_valid     lane sample valid
//   sync_in       frame sync, marks the current sample as index 0
//   coeffs        tap j at [COEFF_WIDTH*j +: COEFF_WIDTH]
//   coeff_valid   din_valid delayed by 2
//   sync_out      sync_in delayed by 2
module pfb_coeff_ctrl #(
  parameter int unsigned TAPS        = 4,
  parameter int unsigned PFB_SIZE    = 64,
  parameter int unsigned COEFF_WIDTH = 18,
  localparam int unsigned IDX_W      = $clog2(PFB_SIZE),
  localparam int unsigned TAP_W      = $clog2(TAPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TAP_W+IDX_W-1:0]      cfg_addr,
  input  logic [COEFF_WIDTH-1:0]      cfg_data,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic                        cfg_err,
  input  logic                        commit,
  output logic                        commit_done,
  output logic                        active_bank,
  input  logic                        din_valid,
  input  logic                        sync_in,
  output logic [TAPS*COEFF_WIDTH-1:0] coeffs,
  output logic                        coeff_valid,
  output logic                        sync_out
);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StPending = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [TAP_W-1:0] wr_tap;
  logic [IDX_W-1:0] wr_idx;
  logic             tap_ok;
  logic             wr_acc;
  logic             wr_en;
  logic             swap;
  logic             rd_bank;

  // Stage-1 registers
  logic [IDX_W-1:0] idx_s1;
  logic             bank_s1;
  logic             valid_s1;
  logic             sync_s1;

  assign idx     = sync_in ? '0 : cnt;
  assign wr_tap  = cfg_addr[TAP_W+IDX_W-1 -: TAP_W];
  assign wr_idx  = cfg_addr[IDX_W-1:0];
  assign tap_ok  = 32'(wr_tap) < TAPS;

  assign cfg_ready = (state == StIdle) && !rst;
  assign wr_acc    = cfg_valid && cfg_ready;
  assign wr_en     = wr_acc && tap_ok;

  assign swap    = (state == StPending) && din_valid && (idx == '0);
  // The swapping sample already reads the incoming bank.
  assign rd_bank = active_bank ^ swap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      active_bank <= 1'b0;
      cnt         <= '0;
      cfg_err     <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      cfg_err     <= wr_acc && !tap_ok;
      commit_done <= swap;
      if (swap) active_bank <= ~active_bank;

      if (state == StIdle) begin
        if (commit && cfg_ready) state <= StPending;
      end else begin
        if (swap) state <= StIdle;
      end

      if (din_valid) begin
        cnt <= (idx == IDX_W'(PFB_SIZE - 1)) ? '0 : idx + 1'b1;
      end else if (sync_in) begin
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_s1      <= '0;
      bank_s1     <= 1'b0;
      valid_s1    <= 1'b0;
      sync_s1     <= 1'b0;
      coeff_valid <= 1'b0;
      sync_out    <= 1'b0;
    end else begin
      idx_s1      <= idx;
      bank_s1     <= rd_bank;
      valid_s1    <= din_valid;
      sync_s1     <= sync_in;
      coeff_valid <= valid_s1;
      sync_out    <= sync_s1;
    end
  end

  for (genvar j = 0; j < TAPS; j++) begin : g_tap
    // Both banks of one tap share an array addressed by {bank, index}.
    logic [COEFF_WIDTH-1:0] mem [2*PFB_SIZE];
    logic [COEFF_WIDTH-1:0] tap_q;

    always_ff @(posedge clk) begin
      if (wr_en && (wr_tap == TAP_W'(j))) begin
        mem[{~active_bank, wr_idx}] <= cfg_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        tap_q <= '0;
      end else if (valid_s1) begin
        tap_q <= mem[{bank_s1, idx_s1}];
      end
    end

    assign coeffs[COEFF_WIDTH*j +: COEFF_WIDTH] = tap_q;
  end

endmodule

// File: tb/tb_pfb_coeff_ctrl.sv
// Directed bench for pfb_coeff_ctrl (TAPS=3, PFB_SIZE=64). Bank 1 is loaded with
// j*1000+k, bank 0 with 20000+j*1000+k; expected coefficient words come from that rule.
module tb_pfb_coeff_ctrl;
  localparam int unsigned TAPS     = 3;
  localparam int unsigned PFB_SIZE = 64;
  localparam int unsigned CW       = 18;
  localparam int unsigned WW       = TAPS * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_err;
  logic          commit;
  logic          commit_done;
  logic          active_bank;
  logic          din_valid;
  logic          sync_in;
  logic [WW-1:0] coeffs;
  logic          coeff_valid;
  logic          sync_out;

  always #5 clk = ~clk;

  pfb_coeff_ctrl #(
    .TAPS       (TAPS),
    .PFB_SIZE   (PFB_SIZE),
    .COEFF_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .commit     (commit),
    .commit_done(commit_done),
    .active_bank(active_bank),
    .din_valid  (din_valid),
    .sync_in    (sync_in),
    .coeffs     (coeffs),
    .coeff_valid(coeff_valid),
    .sync_out   (sync_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          v;
    logic          s;
    logic [WW-1:0] c;
  } exp_t;

  exp_t expq[$];
  logic cur_bank;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] word(input logic bank, input int idx);
    logic [WW-1:0] w;
    for (int j = 0; j < int'(TAPS); j++) begin
      w[CW*j +: CW] = CW'(bank ? (j * 1000 + idx) : (20000 + j * 1000 + idx));
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic v, input int tap, input int idx, input int data,
                     input logic cm);
    cfg_valid = v;
    cfg_addr  = {2'(tap), 6'(idx)};
    cfg_data  = CW'(data);
    commit    = cm;
    din_valid = 1'b0;
    sync_in   = 1'b0;
    tick();
    cfg_valid = 1'b0;
    commit    = 1'b0;
  endtask

  // One lane cycle. rb: bank the sample must read; sw: this sample performs the swap;
  // rdy: cfg_ready expected after the edge. Outputs are checked two cycles after issue.
  task automatic smp(input logic v, input logic s, input logic cm, input int idx,
                     input logic rb, input logic sw, input logic rdy);
    exp_t e;
    din_valid = v;
    sync_in   = s;
    commit    = cm;
    cfg_valid = 1'b0;
    e.v = v;
    e.s = s;
    e.c = word(rb, idx);
    expq.push_back(e);
    tick();
    din_valid = 1'b0;
    sync_in   = 1'b0;
    commit    = 1'b0;
    if (sw) cur_bank = ~cur_bank;
    chk1("commit_done", commit_done, sw);
    chk1("active_bank", active_bank, cur_bank);
    chk1("cfg_ready", cfg_ready, rdy);
    if (expq.size() == 2) begin
      e = expq.pop_front();
      chk1("coeff_valid", coeff_valid, e.v);
      chk1("sync_out", sync_out, e.s);
      if (e.v) chkw("coeffs", coeffs, e.c);
    end
  endtask

  task automatic flush(input logic rdy);
    smp(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, rdy);
    smp(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, rdy);
    expq.delete();
  endtask

  initial begin
    cur_bank  = 1'b0;
    rst       = 1'b1;
    cfg_addr  = '0;
    cfg_data  = '0;
    cfg_valid = 1'b0;
    commit    = 1'b0;
    din_valid = 1'b0;
    sync_in   = 1'b0;

    // Reset state
    tick();
    tick();
    chk1("rst_cfg_ready", cfg_ready, 1'b0);
    chk1("rst_active_bank", active_bank, 1'b0);
    chk1("rst_coeff_valid", coeff_valid, 1'b0);
    chk1("rst_sync_out", sync_out, 1'b0);
    chk1("rst_cfg_err", cfg_err, 1'b0);
    chk1("rst_commit_done", commit_done, 1'b0);
    chkw("rst_coeffs", coeffs, '0);
    rst = 1'b0;
    #1;
    chk1("post_rst_cfg_ready", cfg_ready, 1'b1);

    // Load bank 1; the last write carries the commit
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 64; k++)
        cfg(1'b1, j, k, j * 1000 + k, (j == 2) && (k == 63));
    chk1("pend_cfg_ready", cfg_ready, 1'b0);
    chk1("pend_active_bank", active_bank, 1'b0);

    // Two frames; first sample (sync) swaps to bank 1
    for (int i = 0; i < 128; i++)
      smp(1'b1, i == 0, 1'b0, i % 64, 1'b1, i == 0, 1'b1);
    flush(1'b1);

    // Load bank 0, then commit mid-frame at idx 37 with no further syncs; swap at wrap
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 64; k++)
        cfg(1'b1, j, k, 20000 + j * 1000 + k, 1'b0);
    for (int i = 0; i < 200; i++)
      smp(1'b1, i == 0, i == 37, i % 64, (i < 64) ? 1'b1 : 1'b0, i == 64,
          !((i >= 37) && (i < 64)));
    flush(1'b1);

    // 50% valid duty, commit at idx 10, early sync at idx 20 performs the swap
    for (int k = 0; k < 20; k++) begin
      smp(1'b1, k == 0, 1'b0, k, 1'b0, 1'b0, k <= 10);
      smp(1'b0, 1'b0, k == 10, 0, 1'b0, 1'b0, k < 10);
    end
    smp(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    smp(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < 4; k++) begin
      smp(1'b1, 1'b0, 1'b0, k, 1'b1, 1'b0, 1'b1);
      smp(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    end
    // sync without valid restarts the index
    smp(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    smp(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    smp(1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    flush(1'b1);

    // Bad tap address, then traffic dropped while pending
    cfg(1'b1, 3, 7, 12345, 1'b0);
    chk1("bad_cfg_err", cfg_err, 1'b1);
    cfg(1'b0, 0, 0, 0, 1'b0);
    chk1("bad_cfg_err_clear", cfg_err, 1'b0);
    cfg(1'b0, 0, 0, 0, 1'b1);
    chk1("pend2_cfg_ready", cfg_ready, 1'b0);
    cfg(1'b1, 0, 5, 99999, 1'b1);
    chk1("drop_cfg_err", cfg_err, 1'b0);
    cfg(1'b1, 3, 1, 1, 1'b0);
    chk1("drop_bad_cfg_err", cfg_err, 1'b0);
    chk1("pend3_cfg_ready", cfg_ready, 1'b0);
    for (int i = 0; i < 66; i++)
      smp(1'b1, i == 0, 1'b0, i % 64, 1'b0, i == 0, 1'b1);
    flush(1'b1);

    // Reset while pending abandons the swap
    cfg(1'b0, 0, 0, 0, 1'b1);
    chk1("pend4_cfg_ready", cfg_ready, 1'b0);
    rst = 1'b1;
    tick();
    chk1("rstp_cfg_ready", cfg_ready, 1'b0);
    chk1("rstp_active_bank", active_bank, 1'b0);
    chk1("rstp_commit_done", commit_done, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rstp_cfg_ready_after", cfg_ready, 1'b1);
    for (int i = 0; i < 5; i++)
      smp(1'b1, i == 0, 1'b0, i, 1'b0, 1'b0, 1'b1);
    flush(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pfb_coeff_ctrl.md
# pfb_coeff_ctrl

Double-buffered coefficient controller for the real PFB lane. It holds two banks of TAPS×PFB_SIZE window coefficients and accepts host writes into the shadow bank. It swaps banks only on a frame boundary, so no frame is filtered with mixed coefficient sets. It drives the lane's per-sample coefficient word (all TAPS coefficients for one index) aligned with a delayed copy of the sample's valid and sync.

## Interface
- TAPS, 4, number of filter taps (≥2, any integer)
- PFB_SIZE, 64, coefficients per tap (power of two)
- COEFF_WIDTH, 18, coefficient width (signed, opaque to this block)
- IDX_W, $clog2(PFB_SIZE), derived local, index width
- TAP_W, $clog2(TAPS), derived local, tap field width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- cfg_addr  in  TAP_W+IDX_W  {tap, index}; tap in upper bits
- cfg_data  in  COEFF_WIDTH  coefficient to write
- cfg_valid  in  1  write request
- cfg_ready  out  1  write/commit acceptance
- cfg_err  out  1  one-cycle pulse: accepted write with tap ≥ TAPS (discarded)
- commit  in  1  request bank swap (pulse; sampled when cfg_ready=1)
- commit_done  out  1  one-cycle pulse on the cycle the swap takes effect
- active_bank  out  1  bank currently feeding the datapath
- din_valid  in  1  lane sample valid
- sync_in  in  1  frame sync; the sample in the same cycle is index 0
- coeffs  out  TAPS*COEFF_WIDTH  tap j at [COEFF_WIDTH*j +: COEFF_WIDTH]
- coeff_valid  out  1  din_valid delayed 2
- sync_out  out  1  sync_in delayed 2

## Operation
- Storage: banks 0/1, each TAPS independent arrays of PFB_SIZE words. Contents are not reset and must be written before use.
- Sample index: idx = sync_in ? 0 : cnt.
  - On din_valid: cnt <= (idx==PFB_SIZE-1) ? 0 : idx+1.
  - Else if sync_in: cnt <= 0.
  - Else: cnt holds.
- Write path: a write happens when cfg_valid && cfg_ready. It writes cfg_data to bank ~active_bank, tap cfg_addr[upper], index cfg_addr[lower]. If tap ≥ TAPS, there is no write and cfg_err pulses next cycle.
- FSM:
  - IDLE: cfg_ready=1. commit=1 moves to PENDING. A write in the same cycle as commit is accepted and completes before the swap.
  - PENDING: cfg_ready=0, so writes and commits are ignored. Swap condition: din_valid && idx==0. On swap: active_bank toggles, commit_done pulses, state returns to IDLE.
  - No din_valid: PENDING holds indefinitely.
- Bank used by a read: the sample that triggers the swap already reads the new bank. Subsequent samples read it until the next swap.
- Read pipeline:
  - Stage 1 registers idx, bank, din_valid and sync_in.
  - Stage 2 reads all TAPS arrays of the selected bank, registering coeffs, coeff_valid and sync_out.
- Reset (rst=1 at an edge): state IDLE, active_bank=0, cnt=0, pipeline valid/sync cleared, coeffs=0, cfg_err=0, commit_done=0. cfg_ready=0 while rst is high and 1 from the first cycle after. rst mid-PENDING abandons the swap; written shadow data is kept but is not committed.

## Timing
- Sample at cycle t → coeffs/coeff_valid/sync_out valid at t+2; throughput 1 sample/clk.
- commit_done is asserted at t+1 after the swapping sample at t; active_bank changes at t+1.
- Commit accepted at t → cfg_ready=0 from t+1. If the swap sample is at t+1, cfg_ready=1 again at t+2.
- A commit with cfg_ready=1 in the same cycle as an idx==0 sample does not swap that sample. The swap waits for the next frame start.
- A write issued at t is visible to reads at t+1 or later (it lands in the shadow bank, so it only matters after a swap).
- A sync_in mid-frame restarts the index. With PENDING active, that sample (idx 0) performs the swap.

## Test plan
- Reset then load: write bank-1 tap j, index k = j*1000+k. Commit, then run 2 frames of din_valid with sync_in on the first sample. Frame 1 (from the swap sample) shows tap j = j*1000+idx on coeffs at t+2; commit_done pulses once; active_bank=1.
- Mid-frame commit: commit at idx 37 of a 64-sample frame. cfg_ready is 0 until the idx-0 sample. Samples 38..63 use the old bank; idx 0 uses the new bank.
- Wrap without sync: 200 consecutive valid samples with no sync_in. idx wraps 63→0 and coeffs repeat with period 64. The swap occurs at the wrap.
- Gapped valid plus early sync: din_valid 50% duty, then sync_in at idx 20. The next coeffs show index 0. coeff_valid/sync_out are exact 2-cycle copies of the inputs.
- Bad address and ignored traffic: a write with tap=TAPS (TAPS=3) pulses cfg_err and changes no memory. Writes/commits while PENDING are dropped, and bank contents are verified afterwards.
- Reset in PENDING: assert rst for 1 cycle while PENDING. active_bank stays 0, commit_done never pulses, cfg_ready=1 after reset.
